uart_tx_cfg: RTL

//  Configurable UART transmit channel: serialises parallel words onto sdata_tx_out with

---
 rtl/uart_tx_cfg.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-word holding buffer.
// It generates its own baud timing and has a registered, idle-high serial output.
module uart_tx_cfg #(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUDRATE   = 115200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 valid_tx_in,
   output logic                 ready_tx_out,
   input  logic [DATA_BITS-1:0] data_tx_in,
   output logic                 sdata_tx_out,
   output logic                 busy_tx_out,
   output logic                 done_tx_out
);

   localparam int unsigned DIV      = (CLOCK_FREQ + BAUDRATE / 2) / BAUDRATE;
   localparam int unsigned STOP_LEN = STOP_BITS * DIV;
   localparam int unsigned CW       = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
   localparam int unsigned BW       = $clog2(DATA_BITS);

   localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
   end
   if (PARITY > 2) begin : g_chk_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
      $error("uart_tx_cfg: STOP_BITS must be 1..2");
   end
   if (DIV < 2) begin : g_chk_div
      $error("uart_tx_cfg: clocks per bit must be at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] buf_q, buf_d;
   logic                 buf_full_q, buf_full_d;
   logic                 par_q, par_d;
   logic                 line_q, line_d;
   logic                 done_q, done_d;
   logic                 accept;
   logic                 stop_end;

   function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
      return (PARITY == 1) ? ~^w : ^w;
   endfunction

   assign ready_tx_out = !reset && !buf_full_q;
   assign accept       = valid_tx_in && ready_tx_out;
   assign stop_end     = (state_q == S_STOP) && (cnt_q == STOP_LAST);
   assign sdata_tx_out = line_q;
   assign busy_tx_out  = (state_q != S_IDLE);
   assign done_tx_out  = done_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      par_d      = par_q;
      done_d     = 1'b0;
      line_d     = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_START;
               cnt_d   = '0;
               shift_d = data_tx_in;
               par_d   = parity_of(data_tx_in);
            end
         end
         S_START: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (bit_q == DATA_LAST) begin
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (stop_end) begin
               cnt_d  = '0;
               done_d = 1'b1;
               // Buffered word wins; ready is low then, so no accept can collide.
               if (buf_full_q) begin
                  shift_d    = buf_q;
                  par_d      = parity_of(buf_q);
                  buf_full_d = 1'b0;
                  state_d    = S_START;
               end else if (accept) begin
                  shift_d = data_tx_in;
                  par_d   = parity_of(data_tx_in);
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept && state_q != S_IDLE && !stop_end) begin
         buf_d      = data_tx_in;
         buf_full_d = 1'b1;
      end

      case (state_d)
         S_START:  line_d = 1'b0;
         S_DATA:   line_d = shift_d[0];
         S_PARITY: line_d = par_d;
         default:  line_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         par_q      <= 1'b0;
         line_q     <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         par_q      <= par_d;
         line_q     <= line_d;
         done_q     <= done_d;
      end
   end

endmodule
